interrupt_unit: RTL and testbench
=================================

// Module: interrupt_unit
// PURPOSE
//  Parametrised N-channel interrupt controller; successor to the fixed two-line inta/intb logic in the CPU controller.
//  Per-channel edge detect, enable, programmable priority and vector; plus a software-interrupt channel.
//  Arbitrates pending requests, nests by priority, and delivers a vector with a req/ack handshake.
//  Sits between the external IRQ pins and the PC/decoder interrupt path.
// PARAMETERS
//  NUM_IRQ      4        number of hardware interrupt lines (1..16)
//  ADDR_W       16       vector / data bus width
//  PRIO_W       2        priority field width per channel; larger value = more urgent
//  RST_VEC_BASE 16'hFDA9 reset vector of channel 0
//  RST_VEC_STEP 16'h0256 reset vector of channel i = RST_VEC_BASE - i*RST_VEC_STEP
//  SOFT_BASE    16'd29   soft vector = SOFT_BASE + i_soft_num (mod 2^ADDR_W)
// PORTS
//  clk            in   1                   clock, all state on rising edge
//  n_rst          in   1                   asynchronous active-low reset
//  i_irq          in   NUM_IRQ             level inputs, rising edge requests
//  i_data_bus     in   ADDR_W              config write data
//  i_cfg_sel      in   $clog2(NUM_IRQ)+1   channel index for config write
//  i_cfg_vec_we   in   1                   write i_data_bus to vector[i_cfg_sel]
//  i_cfg_ctl_we   in   1                   write {prio,en} = i_data_bus[PRIO_W:0] to channel i_cfg_sel
//  i_soft_req     in   1                   one-cycle software interrupt request
//  i_soft_num     in   5                   software interrupt number
//  i_ack          in   1                   CPU accepts the presented vector
//  i_recovery     in   1                   return from interrupt, one-cycle pulse
//  o_int_req      out  1                   vector valid, held until ack
//  o_int_address  out  ADDR_W              vector; 0 whenever o_int_req=0
//  o_int_id       out  $clog2(NUM_IRQ)+1   winning source; NUM_IRQ = soft
//  o_pending      out  NUM_IRQ+1           pending bits {soft, hw}
//  o_in_service   out  NUM_IRQ+1           in-service bits {soft, hw}
// BEHAVIOUR
//  Reset: all outputs 0; pending/in-service/irq_q = 0; en = 1, prio = 0, vector per RST_VEC_*; state IDLE.
//  Edge detect: irq_q <= i_irq. Pending[i] set at an edge where i_irq[i]=1, irq_q[i]=0, en[i]=1.
//  Soft: i_soft_req=1 sets pending[NUM_IRQ] and latches i_soft_num; a further request while pending overwrites num.
//  Soft priority is below every hardware channel regardless of prio; it has no enable.
//  Disable (en<-0) clears that channel's pending in the same edge. i_cfg_sel >= NUM_IRQ: write ignored.
//  Eligible: pending and priority strictly greater than current level (highest prio among in-service; -1 if none).
//  Arbitration: highest prio wins; ties go to lowest index; soft only if no hardware channel is eligible.
//  FSM IDLE: any eligible -> REQ; latch winner id and vector[id] into output regs; o_int_req=1 next cycle.
//    Latency: first i_irq high sample at edge n -> pending at n -> o_int_req high after edge n+1.
//  REQ: id/address frozen (later config writes or higher requests do not alter them).
//    i_ack=1 -> clear pending[id], set in_service[id], -> SERVICE; o_int_req/o_int_address drop to 0.
//  SERVICE: newly eligible request (strictly above current level) -> REQ (preemption/nesting).
//    i_recovery clears the highest-priority in-service bit (ties: lowest index, soft last); ignored if none.
//    All in-service clear and nothing eligible -> IDLE; otherwise stay or re-enter REQ per eligibility.
//  Simultaneous events on one edge: a new edge on the acked channel re-sets pending (set wins over clear);
//    i_ack and i_recovery in REQ: ack processed first, then recovery applied to the resulting in-service set.
//  i_ack outside REQ: ignored. i_recovery in IDLE/REQ: applied to the in-service set; the FSM state is unchanged.
//  Asynchronous reset mid-handshake: everything returns to its reset value immediately; o_int_req falls without an ack.
// TESTING
//  Reset, then pulse i_irq[0] -> o_int_req=1 two edges later, o_int_address=16'hFDA9, o_int_id=0.
//  Reset; raise i_irq[1] and i_irq[2] (equal prio 0) together -> id=1 (16'hFB53); ack, recovery -> id=2 (16'hF8FD).
//  Set prio[3]=3 and prio[0]=1; service ch0, then raise irq3 -> preempt: req with id=3; ack,
//    recovery -> in_service={ch0}; then recovery -> IDLE.
//  Write vector[2]=16'h1234 and en[2]=0; pulse irq2 -> no req; en[2]=1, pulse -> address 16'h1234.
//  i_soft_req with num=0 alongside i_irq[0] -> hw first (FDA9); after ack+recovery, soft vector 16'd29, id=NUM_IRQ.
//  Assert n_rst low while o_int_req=1 -> outputs 0 at once; vectors back to their defaults; held i_irq high produces no req.

Source files
------------

// File: rtl/interrupt_unit.sv
// N-channel interrupt controller: edge-detected IRQ lines plus one software channel,
// priority arbitration with nesting, and a req/ack vector handshake towards the CPU.
module interrupt_unit #(
    parameter int                NUM_IRQ      = 4,
    parameter int                ADDR_W       = 16,
    parameter int                PRIO_W       = 2,
    parameter logic [ADDR_W-1:0] RST_VEC_BASE = 16'hFDA9,
    parameter logic [ADDR_W-1:0] RST_VEC_STEP = 16'h0256,
    parameter logic [ADDR_W-1:0] SOFT_BASE    = 16'd29
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_IRQ-1:0]           i_irq,
    input  logic [ADDR_W-1:0]            i_data_bus,
    input  logic [$clog2(NUM_IRQ):0]     i_cfg_sel,
    input  logic                         i_cfg_vec_we,
    input  logic                         i_cfg_ctl_we,
    input  logic                         i_soft_req,
    input  logic [4:0]                   i_soft_num,
    input  logic                         i_ack,
    input  logic                         i_recovery,
    output logic                         o_int_req,
    output logic [ADDR_W-1:0]            o_int_address,
    output logic [$clog2(NUM_IRQ):0]     o_int_id,
    output logic [NUM_IRQ:0]             o_pending,
    output logic [NUM_IRQ:0]             o_in_service
);

    localparam int NCH   = NUM_IRQ + 1;
    localparam int ID_W  = $clog2(NUM_IRQ) + 1;
    localparam int LVL_W = PRIO_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t                   state_q;
    logic                     req_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [ID_W-1:0]          id_q;

    logic [NUM_IRQ-1:0]       irq_q;
    logic [NUM_IRQ-1:0]       en_q;
    logic [PRIO_W-1:0]        prio_q [NUM_IRQ];
    logic [ADDR_W-1:0]        vec_q  [NUM_IRQ];
    logic [4:0]               soft_num_q;
    logic [NCH-1:0]           pend_q, pend_d;
    logic [NCH-1:0]           insvc_q, insvc_d;

    logic signed [LVL_W-1:0]  eff [NCH];
    logic [NCH*LVL_W-1:0]     eff_flat;
    logic signed [LVL_W-1:0]  cur_lvl;
    logic signed [LVL_W-1:0]  win_lvl;
    logic                     any_elig;
    logic [ID_W-1:0]          win_idx;
    logic [ADDR_W-1:0]        win_vec;
    logic [NCH-1:0]           ack_mask;

    // Clear the most urgent bit of an in-service set; ascending scan with strict '>' gives lowest index on ties.
    function automatic logic [NCH-1:0] clear_top(input logic [NCH-1:0] s,
                                                 input logic [NCH*LVL_W-1:0] pv);
        logic [NCH-1:0]          r;
        logic                    found;
        int                      top;
        logic signed [LVL_W-1:0] best;
        logic signed [LVL_W-1:0] p;
        r     = s;
        found = 1'b0;
        top   = 0;
        best  = '0;
        for (int i = 0; i < NCH; i++) begin
            p = pv[i*LVL_W +: LVL_W];
            if (s[i] && (!found || p > best)) begin
                found = 1'b1;
                top   = i;
                best  = p;
            end
        end
        if (found) r[top] = 1'b0;
        return r;
    endfunction

    // Hardware prio p ranks as p+1, soft as 0, "nothing in service" as -1.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            eff[i] = LVL_W'(prio_q[i]) + LVL_W'(1);
        end
        eff[NUM_IRQ] = '0;
        for (int i = 0; i < NCH; i++) begin
            eff_flat[i*LVL_W +: LVL_W] = eff[i];
        end
    end

    always_comb begin
        cur_lvl = '1;
        for (int i = 0; i < NCH; i++) begin
            if (insvc_q[i] && eff[i] > cur_lvl) cur_lvl = eff[i];
        end
        any_elig = 1'b0;
        win_idx  = '0;
        win_lvl  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pend_q[i] && eff[i] > cur_lvl && (!any_elig || eff[i] > win_lvl)) begin
                any_elig = 1'b1;
                win_idx  = ID_W'(i);
                win_lvl  = eff[i];
            end
        end
    end

    always_comb begin
        win_vec = SOFT_BASE + ADDR_W'(soft_num_q);
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (win_idx == ID_W'(i)) win_vec = vec_q[i];
        end
    end

    // New edges override the ack clear; a disable write has the final say.
    always_comb begin
        ack_mask = '0;
        if (state_q == S_REQ && i_ack) ack_mask = NCH'(1) << id_q;

        insvc_d = insvc_q | ack_mask;
        if (i_recovery) insvc_d = clear_top(insvc_d, eff_flat);

        pend_d = pend_q & ~ack_mask;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_irq[i] && !irq_q[i] && en_q[i]) pend_d[i] = 1'b1;
            if (i_cfg_ctl_we && i_cfg_sel == ID_W'(i) && !i_data_bus[0]) pend_d[i] = 1'b0;
        end
        if (i_soft_req) pend_d[NUM_IRQ] = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_q      <= '0;
            soft_num_q <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                en_q[i]   <= 1'b1;
                prio_q[i] <= '0;
                vec_q[i]  <= RST_VEC_BASE - ADDR_W'(i) * RST_VEC_STEP;
            end
        end else begin
            irq_q <= i_irq;
            if (i_soft_req) soft_num_q <= i_soft_num;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (i_cfg_vec_we && i_cfg_sel == ID_W'(i)) vec_q[i] <= i_data_bus;
                if (i_cfg_ctl_we && i_cfg_sel == ID_W'(i)) begin
                    en_q[i]   <= i_data_bus[0];
                    prio_q[i] <= i_data_bus[PRIO_W:1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_q  <= '0;
            insvc_q <= '0;
        end else begin
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= win_vec;
                        id_q    <= win_idx;
                    end
                end
                S_REQ: begin
                    if (i_ack) begin
                        state_q <= S_SERVICE;
                        req_q   <= 1'b0;
                        addr_q  <= '0;
                    end
                end
                S_SERVICE: begin
                    if (any_elig) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= win_vec;
                        id_q    <= win_idx;
                    end else if (insvc_d == '0) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign o_int_req     = req_q;
    assign o_int_address = addr_q;
    assign o_int_id      = id_q;
    assign o_pending     = pend_q;
    assign o_in_service  = insvc_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit: reset, arbitration, nesting, config writes,
// software channel and asynchronous reset during a handshake.
module tb_interrupt_unit;

    localparam int NUM_IRQ = 4;
    localparam int ADDR_W  = 16;
    localparam int ID_W    = $clog2(NUM_IRQ) + 1;

    logic               clk = 1'b0;
    logic               n_rst;
    logic [NUM_IRQ-1:0] i_irq;
    logic [ADDR_W-1:0]  i_data_bus;
    logic [ID_W-1:0]    i_cfg_sel;
    logic               i_cfg_vec_we;
    logic               i_cfg_ctl_we;
    logic               i_soft_req;
    logic [4:0]         i_soft_num;
    logic               i_ack;
    logic               i_recovery;
    logic               o_int_req;
    logic [ADDR_W-1:0]  o_int_address;
    logic [ID_W-1:0]    o_int_id;
    logic [NUM_IRQ:0]   o_pending;
    logic [NUM_IRQ:0]   o_in_service;

    int total = 0;
    int bad   = 0;

    interrupt_unit #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_irq        (i_irq),
        .i_data_bus   (i_data_bus),
        .i_cfg_sel    (i_cfg_sel),
        .i_cfg_vec_we (i_cfg_vec_we),
        .i_cfg_ctl_we (i_cfg_ctl_we),
        .i_soft_req   (i_soft_req),
        .i_soft_num   (i_soft_num),
        .i_ack        (i_ack),
        .i_recovery   (i_recovery),
        .o_int_req    (o_int_req),
        .o_int_address(o_int_address),
        .o_int_id     (o_int_id),
        .o_pending    (o_pending),
        .o_in_service (o_in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [NUM_IRQ-1:0] m);
        i_irq = m;
        step();
        i_irq = '0;
    endtask

    task automatic cfg_vec(input logic [ID_W-1:0] sel, input logic [ADDR_W-1:0] d);
        i_cfg_sel = sel; i_data_bus = d; i_cfg_vec_we = 1'b1;
        step();
        i_cfg_vec_we = 1'b0;
    endtask

    task automatic cfg_ctl(input logic [ID_W-1:0] sel, input logic [ADDR_W-1:0] d);
        i_cfg_sel = sel; i_data_bus = d; i_cfg_ctl_we = 1'b1;
        step();
        i_cfg_ctl_we = 1'b0;
    endtask

    task automatic do_ack();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
    endtask

    task automatic do_recov();
        i_recovery = 1'b1;
        step();
        i_recovery = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; i_irq = '0; i_data_bus = '0; i_cfg_sel = '0;
        i_cfg_vec_we = 1'b0; i_cfg_ctl_we = 1'b0; i_soft_req = 1'b0;
        i_soft_num = '0; i_ack = 1'b0; i_recovery = 1'b0;
        step(); step();
        chk("rst_req",   32'(o_int_req),     32'h0);
        chk("rst_addr",  32'(o_int_address), 32'h0);
        chk("rst_id",    32'(o_int_id),      32'h0);
        chk("rst_pend",  32'(o_pending),     32'h0);
        chk("rst_insvc", 32'(o_in_service),  32'h0);
        n_rst = 1'b1;
        step();

        // single request on channel 0
        pulse_irq(4'b0001);
        chk("t1_pend",   32'(o_pending),     32'h01);
        chk("t1_req_lo", 32'(o_int_req),     32'h0);
        step();
        chk("t1_req",    32'(o_int_req),     32'h1);
        chk("t1_addr",   32'(o_int_address), 32'hFDA9);
        chk("t1_id",     32'(o_int_id),      32'h0);
        do_ack();
        chk("t1_ack_req",  32'(o_int_req),     32'h0);
        chk("t1_ack_addr", 32'(o_int_address), 32'h0);
        chk("t1_insvc",    32'(o_in_service),  32'h01);
        chk("t1_pend_clr", 32'(o_pending),     32'h00);
        do_recov();
        chk("t1_rec",    32'(o_in_service),  32'h00);

        // equal-priority tie
        pulse_irq(4'b0110);
        step();
        chk("t2_id1",    32'(o_int_id),      32'h1);
        chk("t2_addr1",  32'(o_int_address), 32'hFB53);
        do_ack();
        do_recov();
        step();
        chk("t2_req2",   32'(o_int_req),     32'h1);
        chk("t2_id2",    32'(o_int_id),      32'h2);
        chk("t2_addr2",  32'(o_int_address), 32'hF8FD);
        do_ack();
        chk("t2_pend",   32'(o_pending),     32'h00);
        do_recov();

        // nesting: prio[3]=3, prio[0]=1
        cfg_ctl(3'd3, 16'h0007);
        cfg_ctl(3'd0, 16'h0003);
        pulse_irq(4'b0001);
        step();
        chk("t3_id0",    32'(o_int_id),      32'h0);
        do_ack();
        chk("t3_insvc0", 32'(o_in_service),  32'h01);
        pulse_irq(4'b1000);
        step();
        chk("t3_req3",   32'(o_int_req),     32'h1);
        chk("t3_id3",    32'(o_int_id),      32'h3);
        chk("t3_addr3",  32'(o_int_address), 32'hF6A7);
        do_ack();
        chk("t3_nest",   32'(o_in_service),  32'h09);
        do_recov();
        chk("t3_rec1",   32'(o_in_service),  32'h01);
        do_recov();
        chk("t3_rec2",   32'(o_in_service),  32'h00);
        chk("t3_idle",   32'(o_int_req),     32'h0);

        // vector write, disable, re-enable
        cfg_vec(3'd2, 16'h1234);
        cfg_ctl(3'd2, 16'h0000);
        pulse_irq(4'b0100);
        step(); step();
        chk("t4_noreq",  32'(o_int_req),     32'h0);
        chk("t4_nopend", 32'(o_pending),     32'h00);
        cfg_ctl(3'd2, 16'h0001);
        pulse_irq(4'b0100);
        step();
        chk("t4_req",    32'(o_int_req),     32'h1);
        chk("t4_addr",   32'(o_int_address), 32'h1234);
        do_ack();
        do_recov();

        // out-of-range selects must not alias a real channel
        cfg_vec(3'd4, 16'hBEEF);
        cfg_ctl(3'd4, 16'h0000);

        // soft request together with hw channel 0
        i_soft_req = 1'b1; i_soft_num = 5'd0; i_irq = 4'b0001;
        step();
        i_soft_req = 1'b0; i_irq = '0;
        chk("t5_pend",   32'(o_pending),     32'h11);
        step();
        chk("t5_hw_id",  32'(o_int_id),      32'h0);
        chk("t5_hw_addr",32'(o_int_address), 32'hFDA9);
        do_ack();
        do_recov();
        step();
        chk("t5_sw_req", 32'(o_int_req),     32'h1);
        chk("t5_sw_id",  32'(o_int_id),      32'h4);
        chk("t5_sw_addr",32'(o_int_address), 32'd29);
        do_ack();
        chk("t5_sw_svc", 32'(o_in_service),  32'h10);
        do_recov();
        chk("t5_sw_rec", 32'(o_in_service),  32'h00);

        // asynchronous reset during a handshake
        cfg_vec(3'd1, 16'hAAAA);
        i_irq = 4'b0010;
        step(); step();
        chk("t6_req",    32'(o_int_req),     32'h1);
        chk("t6_addr",   32'(o_int_address), 32'hAAAA);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_rst_req",  32'(o_int_req),     32'h0);
        chk("t6_rst_addr", 32'(o_int_address), 32'h0);
        chk("t6_rst_pend", 32'(o_pending),     32'h00);
        step(); step();
        chk("t6_held_req",  32'(o_int_req),    32'h0);
        chk("t6_held_pend", 32'(o_pending),    32'h00);
        i_irq = '0;
        n_rst = 1'b1;
        step();
        pulse_irq(4'b0010);
        step();
        chk("t6_post_req",  32'(o_int_req),     32'h1);
        chk("t6_post_addr", 32'(o_int_address), 32'hFB53);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
